// File: rtl/way_data_read_pipe.sv
// Cache way data read pipe: selects the hit way's word(s) and streams them as
// registered response beats, single word or full line critical-word-first.
module way_data_read_pipe #(
  parameter int NUM_WAYS       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFF_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [NUM_WAYS-1:0]                          req_way,
  input  logic [OFF_W-1:0]                             req_word,
  input  logic                                         req_burst,
  input  logic [NUM_WAYS*WORDS_PER_LINE*DATA_WIDTH-1:0] way_data,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [DATA_WIDTH-1:0]                        rsp_data,
  output logic [OFF_W-1:0]                             rsp_word,
  output logic                                         rsp_last,
  output logic                                         rsp_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_e                  state_q;
  logic [OFF_W-1:0]        beat_q;
  logic [NUM_WAYS-1:0]     way_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [OFF_W-1:0]        rsp_word_q;
  logic                    rsp_last_q;
  logic                    rsp_err_q;

  logic                    req_fire;
  logic                    rsp_fire;
  logic                    way_ok;
  logic                    burst_ok;
  logic [OFF_W-1:0]        beat_d;
  logic [OFF_W-1:0]        word_d;

  // OR-reduce across ways of the selected word; word index wraps modulo line length.
  function automatic logic [DATA_WIDTH-1:0] sel_word(
    input logic [NUM_WAYS-1:0]                           way,
    input logic [OFF_W-1:0]                              idx,
    input logic [NUM_WAYS*WORDS_PER_LINE*DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH-1:0] acc;
    acc = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        acc |= (way[w] && (k == (int'(idx) % WORDS_PER_LINE)))
               ? data[(w*WORDS_PER_LINE+k)*DATA_WIDTH +: DATA_WIDTH]
               : {DATA_WIDTH{1'b0}};
      end
    end
    return acc;
  endfunction

  function automatic logic is_onehot(input logic [NUM_WAYS-1:0] way);
    return (way != {NUM_WAYS{1'b0}}) &&
           ((way & (way - {{(NUM_WAYS-1){1'b0}}, 1'b1})) == {NUM_WAYS{1'b0}});
  endfunction

  assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid_q && rsp_ready;
  assign way_ok    = is_onehot(req_way);
  assign burst_ok  = req_burst && (WORDS_PER_LINE > 1);
  assign beat_d    = beat_q + {{(OFF_W-1){1'b0}}, 1'b1};
  assign word_d    = rsp_word_q + {{(OFF_W-1){1'b0}}, 1'b1};

  // Request capture, beat sequencing and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      way_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_word_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_word_q  <= req_word;
            way_q       <= req_way;
            beat_q      <= '0;
            rsp_err_q   <= !way_ok;
            // A bad way vector must not leak OR-ed data from several ways.
            rsp_data_q  <= way_ok ? sel_word(req_way, req_word, way_data) : {DATA_WIDTH{1'b0}};
            rsp_last_q  <= !(way_ok && burst_ok);
            state_q     <= (way_ok && burst_ok) ? BURST : IDLE;
          end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
          end else begin
            rsp_valid_q <= rsp_valid_q;
          end
        end
        BURST: begin
          if (rsp_fire) begin
            if (rsp_last_q) begin
              state_q     <= IDLE;
              rsp_valid_q <= 1'b0;
              beat_q      <= '0;
            end else begin
              beat_q      <= beat_d;
              rsp_word_q  <= word_d;
              rsp_data_q  <= sel_word(way_q, word_d, way_data);
              rsp_last_q  <= (beat_d == LAST_BEAT);
            end
          end else begin
            beat_q <= beat_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_word  = rsp_word_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/way_data_read_pipe.md
WAY_DATA_READ_PIPE -- requirements
Module: way_data_read_pipe

Interface
REQ-001 SHALL provide parameter NUM_WAYS, default 8, number of cache ways (>=1).
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, bits per word.
REQ-003 SHALL provide parameter WORDS_PER_LINE, default 4, words per line (power of 2, >=1); OFF_W = max(1, clog2(WORDS_PER_LINE)).
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port req_valid  input  1  read request present.
REQ-007 SHALL provide port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 SHALL provide port req_way  input  NUM_WAYS  one-hot hit-way vector.
REQ-009 SHALL provide port req_word  input  OFF_W  requested (critical) word offset.
REQ-010 SHALL provide port req_burst  input  1  0 = single word, 1 = full line, critical-word-first.
REQ-011 SHALL provide port way_data  input  NUM_WAYS*WORDS_PER_LINE*DATA_WIDTH  line data; way w word k at bits [(w*WORDS_PER_LINE+k)*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL provide port rsp_valid  output  1  response beat present.
REQ-013 SHALL provide port rsp_ready  input  1  beat consumed when rsp_valid && rsp_ready.
REQ-014 SHALL provide port rsp_data  output  DATA_WIDTH  beat data, registered.
REQ-015 SHALL provide port rsp_word  output  OFF_W  word offset of current beat.
REQ-016 SHALL provide port rsp_last  output  1  final beat of transaction.
REQ-017 SHALL provide port rsp_err  output  1  req_way was zero or multi-hot.

Function
REQ-018 SHALL implement states IDLE and BURST; IDLE->BURST on accepted valid burst request with WORDS_PER_LINE>1; BURST->IDLE on handshake of rsp_last beat.
REQ-019 SHALL drive req_ready = (state==IDLE) && (!rsp_valid || rsp_ready), combinationally.
REQ-020 SHALL latch req_way, req_word, req_burst on acceptance and assert rsp_valid on the next rising edge (latency 1 cycle).
REQ-021 SHALL load rsp_data as the OR over ways of (latched way bit ? way word : 0) at the word index of the beat being loaded.
REQ-022 SHALL, in BURST, load beat n (n=1..WORDS_PER_LINE-1) with word (start+n) mod WORDS_PER_LINE on the edge where the previous beat is handshaken; no bubble between beats.
REQ-023 SHALL hold rsp_valid, rsp_data, rsp_word, rsp_last, rsp_err stable while rsp_valid && !rsp_ready.
REQ-024 SHALL assert rsp_last on single-word beats and on beat WORDS_PER_LINE-1 of a burst.
REQ-025 SHALL treat req_way zero or multi-hot as error: one beat, rsp_err=1, rsp_data=0, rsp_last=1, rsp_word=req_word, no BURST entry, regardless of req_burst.
REQ-026 SHALL, with WORDS_PER_LINE=1, treat burst requests as single-word with rsp_last=1.
REQ-027 SHALL permit back-to-back single-word requests: new request accepted in the same cycle the prior beat is handshaken.
REQ-028 SHALL ignore req_* inputs while req_ready=0; way_data is sampled per beat and SHALL be held stable by the requester for the transaction.
REQ-029 SHALL drop rsp_valid the cycle after the last beat handshake when no new request is accepted.

Reset
REQ-030 SHALL, on rst_n=0, immediately clear rsp_valid, rsp_data, rsp_word, rsp_last, rsp_err to 0, state to IDLE, beat counter to 0.
REQ-031 SHALL abort any in-progress burst on reset; no further beats of that transaction after rst_n rises.
REQ-032 SHALL assert req_ready=1 in the first cycle after rst_n deasserts.

Verification (NUM_WAYS=4, DATA_WIDTH=32, WORDS_PER_LINE=4; way w word k = 0xW0K0_00WK pattern)
REQ-033 Single read: req_way=4'b0100, req_word=2, burst=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=way2 word2, rsp_word=2, rsp_last=1, rsp_err=0.
REQ-034 Burst wrap: req_way=4'b0010, req_word=3, burst=1 -> 4 consecutive beats words 3,0,1,2 of way1; rsp_last only on 4th; req_ready=0 until last handshake.
REQ-035 Backpressure: burst with rsp_ready low 3 cycles on beat 1 -> beat 1 outputs held unchanged, then beats continue in order, no beat lost or duplicated.
REQ-036 Error: req_way=4'b0110, burst=1 -> single beat rsp_err=1, rsp_data=0, rsp_last=1; state stays IDLE.
REQ-037 Reset mid-burst: rst_n low after beat 2 -> all outputs 0 within same cycle; after release req_ready=1, rsp_valid=0.
REQ-038 Back-to-back singles: requests to words 0,1,2 on consecutive cycles with rsp_ready=1 -> rsp_valid continuously high 3 cycles, correct data each cycle.
